gate_eval_arbiter: RTL

GATE_EVAL_ARBITER -- requirements
Module: gate_eval_arbiter

---
 rtl/gate_eval_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/gate_eval_arbiter.sv
// Two-requester round-robin front end sharing one registered gate evaluator.
// Each accepted operand vector settles for SETTLE_CYCLES before its result is offered.
module gate_eval_arbiter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [2:0] req0_abc,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_abc,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic       rsp_q,
  input  logic       rsp_ready,
  output logic       busy,
  output logic [7:0] eval_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt_p0;
  logic [2:0] abc_p0;
  logic       last_grant;
  logic       any_valid;
  logic       gnt_id;
  logic       accept;
  logic       rsp_done;

  function automatic logic eval_q(input logic [2:0] abc);
    logic a, b, c;
    a = abc[2];
    b = abc[1];
    c = abc[0];
    return (a & b) | ((b | c) & (b & c));
  endfunction

  // Round-robin: a lone requester always wins; on contention the one not served last wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) gnt_id = ~last_grant;
    else                          gnt_id = req1_valid;
  end

  assign req0_ready = rst_n && (state == IDLE) && any_valid && !gnt_id;
  assign req1_ready = rst_n && (state == IDLE) && any_valid &&  gnt_id;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign rsp_done   = (state == RESP) && rsp_ready;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)          state_nxt = SETTLE;
      SETTLE:  if (cnt_p0 == 3'd1)  state_nxt = RESP;
      RESP:    if (rsp_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt_p0     <= 3'd0;
      abc_p0     <= 3'd0;
      rsp_id     <= 1'b0;
      rsp_q      <= 1'b0;
      last_grant <= 1'b1;
      eval_count <= 8'd0;
    end else begin
      state <= state_nxt;
      // Stage p0: operand capture on request handshake
      if ((state == IDLE) && accept) begin
        abc_p0 <= gnt_id ? req1_abc : req0_abc;
        rsp_id <= gnt_id;
        cnt_p0 <= SETTLE_LOAD;
      end
      // Stage p1: settle countdown, result sampled on the final settle cycle
      if (state == SETTLE) begin
        cnt_p0 <= 3'(cnt_p0 - 3'd1);
        if (cnt_p0 == 3'd1) rsp_q <= eval_q(abc_p0);
      end
      if (rsp_done) begin
        last_grant <= rsp_id;
        if (eval_count != 8'hFF) eval_count <= eval_count + 8'd1;
      end
    end
  end

endmodule
